// File: rtl/seq_pair_loader_pkg.sv
// Shared definitions for the sequence loader and the future result-side
// blocks: sequence geometry, 2-bit base codes and the loader state type.
package seq_pkg;

  localparam int NBASES = 12;
  localparam int BW     = 2;
  localparam int SEQ_W  = NBASES * BW;
  localparam int CNT_W  = 4;

  localparam logic [BW-1:0] BASE_A = 2'b00;
  localparam logic [BW-1:0] BASE_C = 2'b01;
  localparam logic [BW-1:0] BASE_G = 2'b10;
  localparam logic [BW-1:0] BASE_T = 2'b11;

  typedef enum logic [1:0] {
    LOAD_R = 2'd0,
    LOAD_Q = 2'd1,
    START  = 2'd2,
    WAIT   = 2'd3
  } loader_state_t;

endpackage

// File: rtl/seq_pair_loader_if.sv
// Byte-stream input and accelerator-side signals of the sequence loader.
// The slave modport is the loader's view; master is the environment's view.
interface seq_pair_loader_if;
  import seq_pkg::*;

  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic [SEQ_W-1:0] R;
  logic [SEQ_W-1:0] Q;
  logic             start;
  logic             acc_ready;
  logic             busy;
  logic             err;
  logic [7:0]       jobs;

  modport slave (
    input  in_valid, in_data, acc_ready,
    output in_ready, R, Q, start, busy, err, jobs
  );

  modport master (
    output in_valid, in_data, acc_ready,
    input  in_ready, R, Q, start, busy, err, jobs
  );

endinterface

// File: rtl/seq_pair_loader_ascii_base_enc.sv
// ASCII nucleotide to 2-bit code. Unknown bytes map to A and raise illegal.
module ascii_base_enc
  import seq_pkg::*;
(
  input  logic [7:0]    char_i,
  output logic [BW-1:0] code_o,
  output logic          illegal_o
);

  // Case-insensitive decode of A/C/G/T; everything else is flagged.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    code_o    = BASE_A;
    illegal_o = 1'b0;
    case (char_i)
      8'h41, 8'h61: code_o = BASE_A;  // 'A' 'a'
      8'h43, 8'h63: code_o = BASE_C;  // 'C' 'c'
      8'h47, 8'h67: code_o = BASE_G;  // 'G' 'g'
      8'h54, 8'h74: code_o = BASE_T;  // 'T' 't'
      default:      illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/seq_pair_loader.sv
// Loads 12 reference then 12 query bases from a byte stream, pulses start,
// and holds R/Q until the accelerator's ready rises again.
module seq_pair_loader
  import seq_pkg::*;
(
  input  logic clk,
  input  logic reset,
  seq_pair_loader_if.slave bus
);

  loader_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEQ_W-1:0] r_q, r_d;
  logic [SEQ_W-1:0] q_q, q_d;
  logic             err_q, err_d;
  logic [7:0]       jobs_q, jobs_d;
  logic             acc_prev_q;

  logic [BW-1:0] code;
  logic          illegal;
  logic          xfer;
  logic          last_base;
  logic          acc_rise;

  ascii_base_enc u_enc (
    .char_i    (bus.in_data),
    .code_o    (code),
    .illegal_o (illegal)
  );

  // Handshake and accelerator controls depend on registered state only.
  assign bus.in_ready = (state_q == LOAD_R) || (state_q == LOAD_Q);
  assign bus.start    = (state_q == START);
  assign bus.busy     = (state_q == START) || (state_q == WAIT);
  assign bus.R        = r_q;
  assign bus.Q        = q_q;
  assign bus.err      = err_q;
  assign bus.jobs     = jobs_q;

  assign xfer      = bus.in_valid && bus.in_ready;
  assign last_base = (cnt_q == CNT_W'(NBASES - 1));
  // A level left high by the previous job must not count as completion.
  assign acc_rise  = bus.acc_ready && !acc_prev_q;

  // Next-state logic: shift bases in, sequence the job, count completions.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    err_d   = err_q;
    jobs_d  = jobs_q;
    case (state_q)
      LOAD_R: begin
        if (xfer) begin
          r_d   = {r_q[SEQ_W-BW-1:0], code};
          // The first byte of a job starts a fresh error history.
          err_d = (cnt_q == '0) ? illegal : (err_q | illegal);
          if (last_base) begin
            cnt_d   = '0;
            state_d = LOAD_Q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      LOAD_Q: begin
        if (xfer) begin
          q_d   = {q_q[SEQ_W-BW-1:0], code};
          err_d = err_q | illegal;
          if (last_base) begin
            cnt_d   = '0;
            state_d = START;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (acc_rise) begin
          jobs_d  = jobs_q + 8'd1;
          state_d = LOAD_R;
        end
      end
      default: state_d = LOAD_R;
    endcase
  end

  // State, datapath and edge-detector registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the R/Q shift registers are reset too, because they drive the
      // accelerator directly and a discarded partial load must not leak out.
      state_q    <= LOAD_R;
      cnt_q      <= '0;
      r_q        <= '0;
      q_q        <= '0;
      err_q      <= 1'b0;
      jobs_q     <= '0;
      acc_prev_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      r_q        <= r_d;
      q_q        <= q_d;
      err_q      <= err_d;
      jobs_q     <= jobs_d;
      acc_prev_q <= bus.acc_ready;
    end
  end

endmodule

// File: tb/tb_seq_pair_loader.sv
// Scoreboarded bench for seq_pair_loader: directed jobs push expected R/Q/err,
// a monitor pops and compares on every start pulse.
module tb_seq_pair_loader;
  import seq_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_pair_loader_if bus ();

  seq_pair_loader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [SEQ_W-1:0] r;
    logic [SEQ_W-1:0] q;
    logic             err;
  } exp_t;

  exp_t sb[$];
  int   errors    = 0;
  int   checks    = 0;
  int   exp_jobs  = 0;
  logic [SEQ_W-1:0] cur_r, cur_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit legal(input byte c);
    case (c)
      "A", "a", "C", "c", "G", "g", "T", "t": return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Monitor: each start pulse must match the oldest outstanding job.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && bus.start === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_start", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("R_at_start", bus.R, e.r);
          check("Q_at_start", bus.Q, e.q);
          check("err_at_start", bus.err, e.err);
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("in_ready_timeout", 32'd0, 32'd1);
  endtask

  // Offer each character; gap inserts an idle cycle between transfers.
  task automatic send_seq(input string s, input bit gap, input bit chk_first);
    for (int i = 0; i < s.len(); i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = s[i];
      wait_ready();
      @(negedge clk);
      if (chk_first && i == 0) check("err_first_byte", bus.err, {31'd0, !legal(s[0])});
      if (gap && i < s.len() - 1) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("in_ready_gap", bus.in_ready, 32'd1);
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic run_job(input string rs, input string qs, input bit gap,
                         input logic [SEQ_W-1:0] er, input logic [SEQ_W-1:0] eq,
                         input logic ee);
    sb.push_back('{r: er, q: eq, err: ee});
    send_seq(rs, gap, 1'b1);
    send_seq(qs, gap, 1'b0);
    check("start_after_24th", bus.start, 32'd1);
    check("in_ready_in_start", bus.in_ready, 32'd0);
    @(negedge clk);
    check("start_one_cycle", bus.start, 32'd0);
    check("busy_in_wait", bus.busy, 32'd1);
    cur_r = er;
    cur_q = eq;
  endtask

  // Hold acc_ready high for hold cycles, then drop and raise it.
  task automatic complete(input int hold, input bit offer);
    if (offer) begin
      bus.in_valid = 1'b1;
      bus.in_data  = "G";
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("wait_busy", bus.busy, 32'd1);
      check("wait_in_ready", bus.in_ready, 32'd0);
      check("wait_R_stable", bus.R, cur_r);
      check("wait_Q_stable", bus.Q, cur_q);
      check("wait_jobs", bus.jobs, exp_jobs);
    end
    bus.acc_ready = 1'b0;
    @(negedge clk);
    check("busy_acc_low", bus.busy, 32'd1);
    bus.acc_ready = 1'b1;
    @(negedge clk);
    exp_jobs = (exp_jobs + 1) % 256;
    check("in_ready_after_done", bus.in_ready, 32'd1);
    check("busy_after_done", bus.busy, 32'd0);
    check("jobs_count", bus.jobs, exp_jobs);
    check("R_after_done", bus.R, cur_r);
    check("Q_after_done", bus.Q, cur_q);
  endtask

  task automatic check_reset_values();
    check("rst_R", bus.R, 32'd0);
    check("rst_Q", bus.Q, 32'd0);
    check("rst_start", bus.start, 32'd0);
    check("rst_busy", bus.busy, 32'd0);
    check("rst_err", bus.err, 32'd0);
    check("rst_jobs", bus.jobs, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.acc_ready = 1'b1;
    #12;
    check_reset_values();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("in_ready_after_reset", bus.in_ready, 32'd1);

    // Basic job, then a WAIT with acc_ready still high from before.
    run_job("ACGTACGTACGT", "TTTTTTTTTTTT", 1'b0, 24'h1B1B1B, 24'hFFFFFF, 1'b0);
    complete(3, 1'b0);

    // Lowercase input.
    run_job("acgtacgtacgt", "GGGGCCCCAAAA", 1'b0, 24'h1B1B1B, 24'hAA5500, 1'b0);
    complete(0, 1'b0);

    // Illegal first byte encodes as A and sets err.
    run_job("NCGTACGTACGT", "tttttttttttt", 1'b0, 24'h1B1B1B, 24'hFFFFFF, 1'b1);
    complete(2, 1'b0);
    check("err_sticky_after_job", bus.err, 32'd1);

    // Toggling in_valid; err cleared on first byte; bytes offered in WAIT.
    run_job("TGCATGCATGCA", "CCCCCCCCCCCC", 1'b1, 24'hE4E4E4, 24'h555555, 1'b0);
    complete(4, 1'b1);

    // The G held through WAIT must become R base 0, consumed exactly once.
    run_job("GAAAAAAAAAAA", "AAAAAAAAAAAT", 1'b0, 24'h800000, 24'h000003, 1'b0);
    complete(1, 1'b0);

    // Reset after 7 R bases discards the partial load.
    send_seq("CGTACGT", 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    check_reset_values();
    exp_jobs = 0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("in_ready_after_rereset", bus.in_ready, 32'd1);

    run_job("CCCCCCCCCCCC", "ACGTACGTACGT", 1'b0, 24'h555555, 24'h1B1B1B, 1'b0);
    complete(1, 1'b0);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_pair_loader.md
# seq_pair_loader

Front-end writer for the banded Smith-Waterman accelerator: accepts an ASCII nucleotide byte stream over a valid/ready handshake, packs 12 reference bases then 12 query bases into the 24-bit 2-bit-per-base `R`/`Q` buses, pulses the accelerator's `start`, then holds both buses stable until the accelerator signals completion. It replaces the static sequence memory feeding the accelerator in system builds.

## Interface
- `NBASES`, 12: bases per sequence.
- `BW`, 2: bits per encoded base; `R`/`Q` width = `NBASES*BW` = 24.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  byte on `in_data` valid.
- `in_data`  in  8  ASCII base character.
- `in_ready`  out  1  loader can accept a byte.
- `R`  out  24  packed reference sequence.
- `Q`  out  24  packed query sequence.
- `start`  out  1  one-cycle active-high pulse to accelerator `start`.
- `acc_ready`  in  1  accelerator `ready`.
- `busy`  out  1  job issued, waiting on accelerator.
- `err`  out  1  sticky: illegal character seen in current job.
- `jobs`  out  8  completed-job counter, wraps 255→0.

## Operation
- Encoding: A/a=00, C/c=01, G/g=10, T/t=11; any other byte → 00 and sets `err`.
- Packing: first accepted base of a sequence lands in bits [23:22], 12th in [1:0] (shift left by 2, insert at LSBs).
- States: `LOAD_R` → `LOAD_Q` → `START` → `WAIT` → `LOAD_R`.
- `LOAD_R`: `in_ready`=1; each transfer (`in_valid && in_ready`) shifts into `R`, increments base counter 0..11; on 12th transfer counter → 0, go `LOAD_Q`. First transfer of a job clears `err` (same-edge illegal char sets it instead).
- `LOAD_Q`: same, into `Q`; on 12th transfer go `START`.
- `START`: `start`=1, `in_ready`=0, `busy`=1; unconditionally → `WAIT`.
- `WAIT`: `in_ready`=0, `busy`=1; leaves only on a rising edge of `acc_ready` (registered previous value 0, current 1); a level high carried over from the previous job is not completion. On exit: `jobs`++ , → `LOAD_R`.
- `R`/`Q` change only in their respective LOAD state; held stable through `START`, `WAIT`, and the whole next job's load of the other bus.
- `in_ready`, `start`, `busy` decoded from registered state (no input→output combinational path).

## Timing
- Reset values: state `LOAD_R`, counter 0, `R`=0, `Q`=0, `start`=0, `busy`=0, `err`=0, `jobs`=0, `acc_ready` history=1; `in_ready`=1 once reset is deasserted.
- Throughput: one base per cycle while `in_valid` held; 24th transfer at edge k → `start` high for exactly cycle k+1 → `WAIT` from edge k+1.
- Earliest completion: `acc_ready` rise sampled at edge ≥ k+2; `LOAD_R` with `in_ready`=1 the next cycle.
- `in_valid` may be asserted in any state; bytes are not consumed outside LOAD states and must be held by the source.
- Reset assertion mid-load or mid-`WAIT`: immediate return to reset values; partial sequence discarded; no `start` issued.

## Structure
- Shared package `seq_pkg`: `NBASES`, `BW`, base-code constants (`BASE_A`..`BASE_T`), state enum `loader_state_t`.
- Sub-module `ascii_base_enc`: combinational byte → {2-bit code, illegal flag}; reused by future result-serializer/decoder blocks.
- Top: state register, 4-bit base counter, two 24-bit shift registers, `acc_ready` edge detector, `jobs` counter.

## Test plan
- Stream "ACGTACGTACGT" then "TTTTTTTTTTTT", `in_valid` constant → `R`=0x1B1B1B, `Q`=0xFFFFFF, single `start` pulse one cycle after 24th byte, `err`=0.
- Same job with lowercase "acgtacgtacgt" → `R`=0x1B1B1B, `err`=0; with 'N' as first R byte → `R`=0x1B1B1B, `err`=1, cleared on first byte of next job.
- `in_valid` toggling every other cycle → same `R`/`Q`; `in_ready` stays 1 until 24th transfer; no byte lost or duplicated.
- `acc_ready` held high from previous job → loader stays in `WAIT`, `busy`=1; drop then raise → `jobs` increments by 1, `in_ready`=1 next cycle; `R`/`Q` unchanged throughout.
- Bytes offered during `WAIT` → `in_ready`=0, not consumed; first byte after completion becomes R base 0.
- Reset asserted after 7 R bases → all outputs at reset values; full new job afterwards yields correct `R`/`Q` with no stale bits.
